// File: rtl/mergesort_pkg.sv
// mergesort_pkg: shared constants, FSM encoding and helpers
// for the in-place bottom-up merge-sort kernel.
package mergesort_pkg;

  localparam int N_ELEM = 28;
  localparam int ELEM_W = 8;
  localparam int IDX_W  = 6;

  localparam int DATA_BASE = 64;
  localparam int TEMP_BASE = 32;

  typedef logic [ELEM_W-1:0] elem_t;
  typedef logic [IDX_W-1:0]  idx_t;

  localparam idx_t LAST_W = idx_t'(16);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PASS_SETUP,
    S_RUN_SETUP,
    S_RD_A,
    S_RD_B,
    S_CMP_WR,
    S_COPY_RD,
    S_COPY_WR,
    S_DONE
  } state_t;

  typedef struct packed {
    logic       oe;
    logic       we;
    logic [6:0] addr;
    elem_t      wdata;
  } slv_req_t;

  function automatic elem_t init_elem(int idx);
    return elem_t'(N_ELEM - 1 - idx);
  endfunction

  function automatic logic addr_hit(
    logic [6:0] a,
    logic [7:0] base
  );
    return ({1'b0, a} >= base) &&
           ({1'b0, a} < base + 8'(N_ELEM));
  endfunction

  function automatic logic [4:0] addr_off(
    logic [6:0] a,
    logic [7:0] base
  );
    return 5'({1'b0, a} - base);
  endfunction

  function automatic idx_t clamp_idx(idx_t v);
    return (v > idx_t'(N_ELEM)) ? idx_t'(N_ELEM) : v;
  endfunction

endpackage

// File: rtl/mergesort_ram.sv
// mergesort_ram: 28x8 array with one sort port and two slave
// ports, synchronous read, contents reloaded on reset.
module mergesort_ram
  import mergesort_pkg::*;
#(
  parameter bit LOAD_INIT = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  sort_addr,
  input  logic        sort_we,
  input  elem_t       sort_wdata,
  output elem_t       sort_rdata,
  input  logic [1:0]  slv_we,
  input  logic [9:0]  slv_addr,
  input  logic [15:0] slv_wdata,
  output logic [15:0] slv_rdata
);

  elem_t mem [N_ELEM];

  function automatic elem_t rd(logic [4:0] a);
    return (a < 5'(N_ELEM)) ? mem[a] : '0;
  endfunction

  // Channel 1 is written last so it wins a same-byte collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < N_ELEM; e++)
        mem[e] <= LOAD_INIT ? init_elem(e) : '0;
      sort_rdata <= '0;
      slv_rdata  <= '0;
    end else begin
      sort_rdata <= rd(sort_addr);
      for (int c = 0; c < 2; c++)
        slv_rdata[8*c +: 8] <= rd(slv_addr[5*c +: 5]);
      if (sort_we && sort_addr < 5'(N_ELEM))
        mem[sort_addr] <= sort_wdata;
      for (int c = 0; c < 2; c++)
        if (slv_we[c] &&
            slv_addr[5*c +: 5] < 5'(N_ELEM))
          mem[slv_addr[5*c +: 5]] <= slv_wdata[8*c +: 8];
    end
  end

endmodule

// File: rtl/mergesort_main.sv
// mergesort_main: bottom-up merge-sort FSM over a data/temp
// RAM pair, with a dual-channel slave port while idle.
module mergesort_main
  import mergesort_pkg::*;
#(
  parameter int MEM_var_28859_28863 = DATA_BASE,
  parameter int MEM_var_28861_28867 = TEMP_BASE,
  parameter int MEM_var_29003_28863 = TEMP_BASE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  input  logic [1:0]  S_oe_ram,
  input  logic [1:0]  S_we_ram,
  input  logic [13:0] S_addr_ram,
  input  logic [15:0] S_Wdata_ram,
  input  logic [7:0]  S_data_ram_size,
  output logic        done_port,
  output logic [15:0] Sout_Rdata_ram,
  output logic [1:0]  Sout_DataRdy
);

  localparam logic [7:0] DATA_LO =
    8'(MEM_var_28859_28863);
  localparam logic [7:0] TEMP_LO =
    8'(MEM_var_28861_28867);
  localparam logic [7:0] TEMP_ALIAS =
    8'(MEM_var_29003_28863);

  state_t state, nxt;

  idx_t  lo, mid, hi, i, j, k, w;
  idx_t  k_inc, w2, lo_nxt;
  elem_t a_q;
  logic  idle, at_hi, pass_end, take_left;

  logic [4:0] d_addr;
  logic       d_we, t_we;
  elem_t      d_rd, t_rd, t_wdata;

  slv_req_t    req [2];
  logic [1:0]  d_swe, t_swe;
  logic [9:0]  d_saddr, t_saddr;
  logic [15:0] s_wdata, d_srd, t_srd;
  logic [1:0]  rdy_q, rd_d_q, rd_t_q;

  // Every access is 8 bits wide whatever size is requested.
  logic unused_size;
  assign unused_size = ^S_data_ram_size;

  assign idle      = (state == S_IDLE);
  assign k_inc     = k + idx_t'(1);
  assign at_hi     = (k_inc == hi);
  assign w2        = {w[4:0], 1'b0};
  assign lo_nxt    = lo + w2;
  assign pass_end  = (lo_nxt >= idx_t'(N_ELEM));
  assign take_left = (i < mid) &&
                     ((j >= hi) || (a_q <= d_rd));
  assign done_port = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:       if (start_port) nxt = S_PASS_SETUP;
      S_PASS_SETUP: nxt = S_RUN_SETUP;
      S_RUN_SETUP:  nxt = S_RD_A;
      S_RD_A:       nxt = S_RD_B;
      S_RD_B:       nxt = S_CMP_WR;
      S_CMP_WR:     nxt = at_hi ? S_COPY_RD : S_RD_A;
      S_COPY_RD:    nxt = S_COPY_WR;
      S_COPY_WR: begin
        if (!at_hi)          nxt = S_COPY_RD;
        else if (!pass_end)  nxt = S_RUN_SETUP;
        else if (w == LAST_W) nxt = S_DONE;
        else                 nxt = S_PASS_SETUP;
      end
      S_DONE:       nxt = S_IDLE;
      default:      nxt = S_IDLE;
    endcase
  end

  // k walks the output run during merge, then again for copy-back.
  always_ff @(posedge clock) begin
    if (reset) begin
      lo  <= '0;
      mid <= '0;
      hi  <= '0;
      i   <= '0;
      j   <= '0;
      k   <= '0;
      w   <= idx_t'(1);
      a_q <= '0;
    end else begin
      unique case (state)
        S_IDLE:       w  <= idx_t'(1);
        S_PASS_SETUP: lo <= '0;
        S_RUN_SETUP: begin
          mid <= clamp_idx(lo + w);
          hi  <= clamp_idx(lo_nxt);
          i   <= lo;
          j   <= clamp_idx(lo + w);
          k   <= lo;
        end
        S_RD_B:       a_q <= d_rd;
        S_CMP_WR: begin
          if (take_left) i <= i + idx_t'(1);
          else           j <= j + idx_t'(1);
          k <= at_hi ? lo : k_inc;
        end
        S_COPY_WR: begin
          k <= k_inc;
          if (at_hi) begin
            lo <= lo_nxt;
            if (pass_end) w <= w2;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    d_addr = j[4:0];
    unique case (1'b1)
      state == S_RD_A:    d_addr = i[4:0];
      state == S_COPY_WR: d_addr = k[4:0];
      default: ;
    endcase
  end

  assign d_we    = (state == S_COPY_WR);
  assign t_we    = (state == S_CMP_WR);
  assign t_wdata = take_left ? a_q : d_rd;

  always_comb begin
    for (int c = 0; c < 2; c++)
      req[c] = {S_oe_ram[c], S_we_ram[c],
                S_addr_ram[7*c +: 7],
                S_Wdata_ram[8*c +: 8]};
  end

  always_comb begin
    d_swe   = '0;
    t_swe   = '0;
    d_saddr = '0;
    t_saddr = '0;
    s_wdata = '0;
    for (int c = 0; c < 2; c++) begin
      d_saddr[5*c +: 5] = addr_off(req[c].addr, DATA_LO);
      t_saddr[5*c +: 5] = addr_off(req[c].addr, TEMP_ALIAS);
      s_wdata[8*c +: 8] = req[c].wdata;
      d_swe[c] = idle && req[c].we &&
                 addr_hit(req[c].addr, DATA_LO);
      t_swe[c] = idle && req[c].we &&
                 addr_hit(req[c].addr, TEMP_LO);
    end
  end

  // A request with both oe and we is a write and returns no data.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdy_q  <= '0;
      rd_d_q <= '0;
      rd_t_q <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        rdy_q[c]  <= idle && (req[c].oe || req[c].we);
        rd_d_q[c] <= idle && req[c].oe && !req[c].we &&
                     addr_hit(req[c].addr, DATA_LO);
        rd_t_q[c] <= idle && req[c].oe && !req[c].we &&
                     addr_hit(req[c].addr, TEMP_LO);
      end
    end
  end

  assign Sout_DataRdy = rdy_q;

  always_comb begin
    Sout_Rdata_ram = '0;
    for (int c = 0; c < 2; c++) begin
      unique case (1'b1)
        rd_d_q[c]: Sout_Rdata_ram[8*c +: 8] = d_srd[8*c +: 8];
        rd_t_q[c]: Sout_Rdata_ram[8*c +: 8] = t_srd[8*c +: 8];
        default: ;
      endcase
    end
  end

  mergesort_ram #(
    .LOAD_INIT (1'b1)
  ) u_data (
    .clock      (clock),
    .reset      (reset),
    .sort_addr  (d_addr),
    .sort_we    (d_we),
    .sort_wdata (t_rd),
    .sort_rdata (d_rd),
    .slv_we     (d_swe),
    .slv_addr   (d_saddr),
    .slv_wdata  (s_wdata),
    .slv_rdata  (d_srd)
  );

  mergesort_ram #(
    .LOAD_INIT (1'b0)
  ) u_temp (
    .clock      (clock),
    .reset      (reset),
    .sort_addr  (k[4:0]),
    .sort_we    (t_we),
    .sort_wdata (t_wdata),
    .sort_rdata (t_rd),
    .slv_we     (t_swe),
    .slv_addr   (t_saddr),
    .slv_wdata  (s_wdata),
    .slv_rdata  (t_srd)
  );

endmodule

// File: tb/tb_mergesort_main.sv
// tb_mergesort_main: directed bench with a byte-array model
// of both buffers and a per-cycle slave-port checker.
module tb_mergesort_main;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_port = 1'b0;
  logic [1:0]  S_oe_ram = '0;
  logic [1:0]  S_we_ram = '0;
  logic [13:0] S_addr_ram = '0;
  logic [15:0] S_Wdata_ram = '0;
  logic [7:0]  S_data_ram_size = 8'h88;
  logic        done_port;
  logic [15:0] Sout_Rdata_ram;
  logic [1:0]  Sout_DataRdy;

  mergesort_main dut (
    .clock           (clock),
    .reset           (reset),
    .start_port      (start_port),
    .S_oe_ram        (S_oe_ram),
    .S_we_ram        (S_we_ram),
    .S_addr_ram      (S_addr_ram),
    .S_Wdata_ram     (S_Wdata_ram),
    .S_data_ram_size (S_data_ram_size),
    .done_port       (done_port),
    .Sout_Rdata_ram  (Sout_Rdata_ram),
    .Sout_DataRdy    (Sout_DataRdy)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  bit tb_busy = 1'b0;
  bit primed = 1'b0;

  int mdata [28];
  int mtemp [28];
  bit exp_rdy [2];
  bit exp_rd [2];
  int exp_val [2];

  int pat [28] = '{5, 5, 3, 200, 0, 17, 3, 255, 1, 99,
                   42, 5, 8, 8, 7, 6, 128, 64, 3, 2,
                   1, 0, 77, 250, 9, 10, 11, 12};

  task automatic check(string name, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, got, exp);
  endtask

  task automatic model_reset();
    for (int e = 0; e < 28; e++) begin
      mdata[e] = 27 - e;
      mtemp[e] = 0;
    end
  endtask

  function automatic int model_rd(int a);
    if (a >= 64 && a < 92) return mdata[a - 64];
    if (a >= 32 && a < 60) return mtemp[a - 32];
    return 0;
  endfunction

  task automatic model_wr(int a, int v);
    if (a >= 64 && a < 92) mdata[a - 64] = v;
    if (a >= 32 && a < 60) mtemp[a - 32] = v;
  endtask

  // After the last pass temp holds the fully merged array too.
  task automatic model_sort();
    int q [$];
    q = {};
    for (int e = 0; e < 28; e++) q.push_back(mdata[e]);
    q.sort();
    for (int e = 0; e < 28; e++) begin
      mdata[e] = q[e];
      mtemp[e] = q[e];
    end
  endtask

  always @(negedge clock)
    if (done_port === 1'b1) done_cnt++;

  always @(negedge clock) begin
    int a;
    if (primed) begin
      for (int c = 0; c < 2; c++) begin
        check($sformatf("rdy_ch%0d", c),
              int'(Sout_DataRdy[c]), int'(exp_rdy[c]));
        if (exp_rd[c])
          check($sformatf("rdata_ch%0d", c),
                int'(Sout_Rdata_ram[8*c +: 8]), exp_val[c]);
      end
    end
    primed = 1'b1;
    if (reset) begin
      model_reset();
      for (int c = 0; c < 2; c++) begin
        exp_rdy[c] = 1'b0;
        exp_rd[c]  = 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        a = int'(S_addr_ram[7*c +: 7]);
        exp_rdy[c] = !tb_busy &&
                     (S_oe_ram[c] || S_we_ram[c]);
        exp_rd[c]  = exp_rdy[c] && !S_we_ram[c];
        exp_val[c] = model_rd(a);
      end
      for (int c = 0; c < 2; c++)
        if (!tb_busy && S_we_ram[c])
          model_wr(int'(S_addr_ram[7*c +: 7]),
                   int'(S_Wdata_ram[8*c +: 8]));
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic sop(logic [1:0] oe, logic [1:0] we,
                     int a0, int a1, int w0, int w1);
    @(posedge clock);
    #1;
    S_oe_ram    = oe;
    S_we_ram    = we;
    S_addr_ram  = {7'(a1), 7'(a0)};
    S_Wdata_ram = {8'(w1), 8'(w0)};
    @(posedge clock);
    #1;
    S_oe_ram = '0;
    S_we_ram = '0;
  endtask

  task automatic sread(int a0, int a1,
                       output int v0, output int v1);
    sop(2'b11, 2'b00, a0, a1, 0, 0);
    @(negedge clock);
    v0 = int'(Sout_Rdata_ram[7:0]);
    v1 = int'(Sout_Rdata_ram[15:8]);
  endtask

  task automatic readback();
    int v0, v1;
    for (int e = 0; e < 14; e++)
      sread(64 + 2*e, 65 + 2*e, v0, v1);
  endtask

  task automatic kick();
    @(posedge clock);
    #1;
    start_port = 1'b1;
    tb_busy    = 1'b1;
    @(posedge clock);
    #1;
    start_port = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 1000) begin
      @(negedge clock);
      lat++;
      seen = (done_port === 1'b1);
    end
    check("done_seen", int'(seen), 1);
    model_sort();
    tb_busy = 1'b0;
    @(negedge clock);
    check("done_single", int'(done_port), 0);
  endtask

  initial begin
    int v0, v1, lat1, lat2, lat3, d0;
    model_reset();
    tick(3);
    @(negedge clock);
    check("rst_done", int'(done_port), 0);
    check("rst_rdy", int'(Sout_DataRdy), 0);
    check("rst_rdata", int'(Sout_Rdata_ram), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    sread(64, 91, v0, v1);
    check("init_lo", v0, 27);
    check("init_hi", v1, 0);
    sread(32, 59, v0, v1);
    check("temp_lo", v0, 0);
    check("temp_hi", v1, 0);

    kick();
    wait_done(lat1);
    readback();
    sread(64, 91, v0, v1);
    check("sort1_lo", v0, 0);
    check("sort1_hi", v1, 27);

    for (int e = 0; e < 14; e++)
      sop(2'b00, 2'b11, 64 + 2*e, 65 + 2*e,
          pat[2*e], pat[2*e + 1]);
    readback();
    kick();
    wait_done(lat2);
    check("lat_data_indep", lat2, lat1);
    readback();
    sread(64, 91, v0, v1);
    check("pat_min", v0, 0);
    check("pat_max", v1, 255);
    sread(66, 90, v0, v1);
    check("pat_idx2", v0, 1);
    check("pat_idx26", v1, 250);

    kick();
    wait_done(lat3);
    check("lat_sorted", lat3, lat1);
    readback();
    sread(72, 84, v0, v1);
    check("sorted_idx8", v0, 5);
    check("sorted_idx20", v1, 42);

    kick();
    tick(40);
    start_port = 1'b1;
    tick(3);
    start_port = 1'b0;
    sop(2'b01, 2'b00, 64, 0, 0, 0);
    wait_done(lat1);
    d0 = done_cnt;
    tick(800);
    check("no_extra_done", done_cnt - d0, 0);
    readback();

    d0 = done_cnt;
    kick();
    tick(100);
    reset   = 1'b1;
    tb_busy = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(800);
    check("abort_no_done", done_cnt - d0, 0);
    sread(64, 91, v0, v1);
    check("abort_lo", v0, 27);
    check("abort_hi", v1, 0);
    readback();

    sop(2'b01, 2'b10, 10, 120, 0, 8'h5A);
    @(negedge clock);
    check("oob_rdy", int'(Sout_DataRdy), 3);
    check("oob_rdata", int'(Sout_Rdata_ram[7:0]), 0);
    readback();

    sop(2'b01, 2'b01, 70, 0, 8'hAA, 0);
    sop(2'b00, 2'b11, 75, 75, 8'h11, 8'h22);
    sop(2'b00, 2'b01, 33, 0, 8'h3C, 0);
    sread(70, 75, v0, v1);
    check("oe_we_write", v0, 8'hAA);
    check("ch1_wins", v1, 8'h22);
    sread(33, 60, v0, v1);
    check("temp_write", v0, 8'h3C);
    check("temp_edge", v1, 0);
    readback();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
